// File: rtl/dbd_pkg.sv
// Shared definitions for the block statistics path: lane geometry, the
// drain state encoding and the per-lane statistics record.
package dbd_pkg;

  localparam int LANE_W    = 8;
  localparam int LANES     = 24;
  localparam int IDX_W     = 5;
  localparam int SUM_W_DEF = 21;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [LANE_W-1:0]    max;
    logic [SUM_W_DEF-1:0] sum;
  } lane_stat_t;

endpackage

// File: rtl/lane_accumulator.sv
// One lane's running peak and saturating sum of Y. Clear has priority over
// accumulate; an idle lane carries zero, so accumulating it is harmless.
module lane_accumulator
  import dbd_pkg::*;
#(
  parameter int SUM_W = 21
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClr,
  input  logic              iEn,
  input  logic [LANE_W-1:0] iPixel,
  output logic [LANE_W-1:0] oMax,
  output logic [SUM_W-1:0]  oSum
);

  logic [SUM_W:0] sumExt;

  // one extra bit catches the carry out so the sum can pin at all-ones
  assign sumExt = {1'b0, oSum} + {{(SUM_W + 1 - LANE_W){1'b0}}, iPixel};

  // peak/sum update with clear priority and saturation
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oMax <= '0;
      oSum <= '0;
    end else if (iClr) begin
      oMax <= '0;
      oSum <= '0;
    end else if (iEn) begin
      if (iPixel > oMax) oMax <= iPixel;
      oSum <= sumExt[SUM_W] ? {SUM_W{1'b1}} : sumExt[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/block_stat_collector.sv
// Collects per-block peak and sum of Y across a block row, snapshots them at
// the row end and streams the snapshot out one block per handshake.
//
// Handshake: a result is transferred on a rising edge where oValid && iReady.
// While oValid is high and iReady is low, oIndex/oRow/oMax/oSum hold stable;
// oValid never drops before its result has been transferred (except iRst).
module block_stat_collector
  import dbd_pkg::*;
#(
  parameter int LANES           = dbd_pkg::LANES,
  parameter int LINES_PER_BLOCK = 90,
  parameter int ROWS            = 12,
  parameter int SUM_W           = SUM_W_DEF
) (
  input  logic                      iODCK,
  input  logic                      iRst,
  input  logic                      iVS,
  input  logic                      iDE,
  input  logic [LANES*LANE_W-1:0]   iPixelData,
  output logic                      oValid,
  input  logic                      iReady,
  output logic [IDX_W-1:0]          oIndex,
  output logic [3:0]                oRow,
  output logic [LANE_W-1:0]         oMax,
  output logic [SUM_W-1:0]          oSum,
  output logic                      oOverrun
);

  localparam int LC_W = (LINES_PER_BLOCK > 1) ? $clog2(LINES_PER_BLOCK) : 1;
  localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LINES_PER_BLOCK - 1);
  localparam logic [3:0]       ROW_LAST = 4'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  logic            dDE;
  logic [LC_W-1:0] lineCnt;
  logic [3:0]      rowCnt;
  logic            lineEnd, rowEnd, busy, snapshot, snapPending;
  logic            accEn, accClr;

  drain_state_e     drainState, drainStateNext;
  logic [IDX_W-1:0] idx, idxNext;

  logic [LANE_W-1:0] accMax    [LANES];
  logic [SUM_W-1:0]  accSum    [LANES];
  logic [LANE_W-1:0] shadowMax [LANES];
  logic [SUM_W-1:0]  shadowSum [LANES];
  logic [3:0]        shadowRow;

  // frame start overrides everything: no line end, no accumulation
  assign lineEnd  = dDE && !iDE && !iVS;
  assign rowEnd   = lineEnd && (lineCnt == LC_LAST);
  // a snapshot waiting to enter DRAIN still owns the shadow registers
  assign busy     = (drainState == DRAIN) || snapPending;
  assign snapshot = rowEnd && !busy;
  assign accEn    = iDE && !iVS;
  assign accClr   = rowEnd || iVS;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_accumulator #(.SUM_W(SUM_W)) u_lane (
      .iClk   (iODCK),
      .iRst   (iRst),
      .iClr   (accClr),
      .iEn    (accEn),
      .iPixel (iPixelData[k*LANE_W +: LANE_W]),
      .oMax   (accMax[k]),
      .oSum   (accSum[k])
    );
  end

  // line/row bookkeeping, snapshot handoff and sticky overrun
  always_ff @(posedge iODCK or posedge iRst) begin
    if (iRst) begin
      dDE         <= 1'b0;
      lineCnt     <= '0;
      rowCnt      <= '0;
      snapPending <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      dDE         <= iDE;
      snapPending <= snapshot;
      if (iVS) begin
        lineCnt <= '0;
        rowCnt  <= '0;
      end else if (lineEnd) begin
        if (rowEnd) begin
          lineCnt <= '0;
          rowCnt  <= (rowCnt == ROW_LAST) ? 4'd0 : rowCnt + 4'd1;
        end else begin
          lineCnt <= lineCnt + 1'b1;
        end
      end
      if (rowEnd && busy) oOverrun <= 1'b1;
    end
  end

  // shadow copy of all lanes and the row number at an accepted row end
  always_ff @(posedge iODCK or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < LANES; k++) begin
        shadowMax[k] <= '0;
        shadowSum[k] <= '0;
      end
      shadowRow <= '0;
    end else if (snapshot) begin
      for (int k = 0; k < LANES; k++) begin
        shadowMax[k] <= accMax[k];
        shadowSum[k] <= accSum[k];
      end
      shadowRow <= rowCnt;
    end
  end

  // drain state register
  always_ff @(posedge iODCK or posedge iRst) begin
    if (iRst) begin
      drainState <= IDLE;
      idx        <= '0;
    end else begin
      drainState <= drainStateNext;
      idx        <= idxNext;
    end
  end

  // drain next-state: start one cycle after the snapshot, step on handshake
  always_comb begin
    drainStateNext = drainState;
    idxNext        = idx;
    case (drainState)
      IDLE: begin
        if (snapPending) begin
          drainStateNext = DRAIN;
          idxNext        = '0;
        end
      end
      DRAIN: begin
        if (iReady) begin
          if (idx == IDX_LAST) begin
            drainStateNext = IDLE;
            idxNext        = '0;
          end else begin
            idxNext = idx + 1'b1;
          end
        end
      end
      default: begin
        drainStateNext = IDLE;
        idxNext        = '0;
      end
    endcase
  end

  assign oValid = (drainState == DRAIN);
  assign oIndex = idx;
  assign oRow   = shadowRow;
  assign oMax   = shadowMax[idx];
  assign oSum   = shadowSum[idx];

endmodule
